// File: rtl/evt_stream_pkg.sv
// Shared types for the event FIFO stream adapter.
// Stats registers are present only with EVT_FIFO_ADAPTER_STATS_EN.
package evt_stream_pkg;

  localparam int EVT_MAX_READ_LATENCY = 4;

  typedef struct packed {
    logic [31:0] beat_cnt;
    logic [31:0] stall_cnt;
  } evt_stream_stats_t;

  function automatic logic [31:0] sat_inc(
    input logic [31:0] v
  );
    return (v == '1) ? v : v + 32'd1;
  endfunction

endpackage

// File: rtl/evt_skid_buffer.sv
// Circular skid buffer holding words returned by the SRAM.
// Read side is registered storage only.
module evt_skid_buffer
  import evt_stream_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 2
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic                         clear,
  input  logic                         write,
  input  logic [DATA_WIDTH-1:0]        write_data,
  input  logic                         read,
  output logic [$clog2(DEPTH+1)-1:0]   occupancy,
  output logic [DATA_WIDTH-1:0]        head_data
);

  localparam int OW = $clog2(DEPTH+1);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]         head_q;
  logic [PW-1:0]         tail_q;
  logic [OW-1:0]         occ_q;

  function automatic logic [PW-1:0] wrap_inc(
    input logic [PW-1:0] p
  );
    return (p == PW'(DEPTH-1)) ? '0 : p + PW'(1);
  endfunction

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      head_q <= '0;
      tail_q <= '0;
      occ_q  <= '0;
    end else if (clear) begin
      head_q <= '0;
      tail_q <= '0;
      occ_q  <= '0;
    end else begin
      if (write) begin
        mem_q[tail_q] <= write_data;
        tail_q        <= wrap_inc(tail_q);
      end
      if (read) begin
        head_q <= wrap_inc(head_q);
      end
      case ({write, read})
        2'b10:   occ_q <= occ_q + OW'(1);
        2'b01:   occ_q <= occ_q - OW'(1);
        default: occ_q <= occ_q;
      endcase
    end
  end

  assign occupancy = occ_q;
  assign head_data = mem_q[head_q];

  // A write into a full buffer without a read would lose a word.
  a_no_overflow: assert property (
    @(posedge clk_i) disable iff (rst_i || clear)
    !(write && !read && occ_q == OW'(DEPTH))
  ) else $fatal(1, "evt_skid_buffer overflow");

endmodule

// File: rtl/evt_fifo_stream_adapter.sv
// SRAM event FIFO read side to valid/ready stream adapter.
// Define EVT_FIFO_ADAPTER_STATS_EN to build the beat/stall counters.
module evt_fifo_stream_adapter
  import evt_stream_pkg::*;
#(
  parameter int DATA_WIDTH   = 32,
  parameter int READ_LATENCY = 1
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  flush_i,
  input  logic                  fifo_empty_i,
  output logic                  fifo_pop_o,
  input  logic [DATA_WIDTH-1:0] fifo_data_i,
  output logic                  valid_o,
  input  logic                  ready_i,
  output logic [DATA_WIDTH-1:0] data_o,
  output logic [31:0]           beat_cnt_o,
  output logic [31:0]           stall_cnt_o
);

  localparam int SKID_DEPTH = READ_LATENCY + 1;
  localparam int CW = $clog2(2*SKID_DEPTH) + 1;
  localparam int OW = $clog2(SKID_DEPTH+1);

  logic [READ_LATENCY-1:0] inflight_q;
  logic [READ_LATENCY-1:0] inflight_d;
  logic [CW-1:0]           inflight_cnt;
  logic [CW-1:0]           demand;
  logic [OW-1:0]           occ;
  logic                    deq;
  logic                    capture;

  assign valid_o = (occ != '0);
  assign deq     = valid_o & ready_i;
  assign capture = inflight_q[READ_LATENCY-1];

  always_comb begin
    inflight_cnt = '0;
    for (int i = 0; i < READ_LATENCY; i++) begin
      inflight_cnt = inflight_cnt + CW'(inflight_q[i]);
    end
  end

  // Words owed to the buffer after this cycle must still fit.
  assign demand = CW'(occ) + inflight_cnt - CW'(deq);

  assign fifo_pop_o = ~rst_i & ~flush_i & ~fifo_empty_i
                    & (demand < CW'(SKID_DEPTH));

  always_comb begin
    inflight_d = (inflight_q << 1)
               | READ_LATENCY'(fifo_pop_o);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i || flush_i) begin
      inflight_q <= '0;
    end else begin
      inflight_q <= inflight_d;
    end
  end

  evt_skid_buffer #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (SKID_DEPTH)
  ) u_skid (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .clear      (flush_i),
    .write      (capture),
    .write_data (fifo_data_i),
    .read       (deq),
    .occupancy  (occ),
    .head_data  (data_o)
  );

`ifdef EVT_FIFO_ADAPTER_STATS_EN
  evt_stream_stats_t stats_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      stats_q <= '0;
    end else begin
      if (deq) begin
        stats_q.beat_cnt <= sat_inc(stats_q.beat_cnt);
      end
      if (valid_o && !ready_i) begin
        stats_q.stall_cnt <= sat_inc(stats_q.stall_cnt);
      end
    end
  end

  assign beat_cnt_o  = stats_q.beat_cnt;
  assign stall_cnt_o = stats_q.stall_cnt;
`else
  assign beat_cnt_o  = '0;
  assign stall_cnt_o = '0;
`endif

endmodule

// File: tb/tb_evt_fifo_stream_adapter.sv
// Scoreboard bench: four adapters, READ_LATENCY 1..4, shared stimulus.
// Upstream FIFO and SRAM latency are modelled with queues.
module tb_evt_fifo_stream_adapter;

  localparam int N = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst;
  logic          flush;
  logic [N-1:0]  ready;
  logic [N-1:0]  empty;
  logic [31:0]   din [N];
  wire  [N-1:0]  pop;
  wire  [N-1:0]  valid;
  wire  [31:0]   dout [N];
  wire  [31:0]   beat [N];
  wire  [31:0]   stall [N];

  for (genvar g = 0; g < N; g++) begin : g_dut
    evt_fifo_stream_adapter #(
      .DATA_WIDTH   (32),
      .READ_LATENCY (g + 1)
    ) u_dut (
      .clk_i        (clk),
      .rst_i        (rst),
      .flush_i      (flush),
      .fifo_empty_i (empty[g]),
      .fifo_pop_o   (pop[g]),
      .fifo_data_i  (din[g]),
      .valid_o      (valid[g]),
      .ready_i      (ready[g]),
      .data_o       (dout[g]),
      .beat_cnt_o   (beat[g]),
      .stall_cnt_o  (stall[g])
    );
  end

  logic [31:0] fq    [N][$];
  logic [31:0] exp_q [N][$];
  logic [31:0] pipe  [N][4];
  int          m_beat  [N];
  int          m_stall [N];
  int          total;
  int          bad;

  function automatic logic [31:0] sx(input int v);
`ifdef EVT_FIFO_ADAPTER_STATS_EN
    return 32'(v);
`else
    return (v == v) ? 32'd0 : 32'd1;
`endif
  endfunction

  task automatic chk(input bit ok, input string name,
                     input int inst, input logic [31:0] act,
                     input logic [31:0] req);
    total++;
    if (!ok) begin
      bad++;
      $display("FAIL %s inst=%0d actual=%0h required=%0h t=%0t",
               name, inst, act, req, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic push_all(input logic [31:0] w);
    for (int i = 0; i < N; i++) begin
      fq[i].push_back(w);
      exp_q[i].push_back(w);
    end
  endtask

  // Upstream FIFO plus SRAM read pipeline, one per adapter.
  task automatic model_loop();
    logic [N-1:0] ps;
    logic         fs;
    logic         rs;
    forever begin
      @(negedge clk);
      ps = pop;
      fs = flush;
      rs = rst;
      @(posedge clk);
      #1;
      for (int i = 0; i < N; i++) begin
        for (int k = 3; k > 0; k--) begin
          pipe[i][k] = pipe[i][k-1];
        end
        if (ps[i] && fq[i].size() != 0) begin
          pipe[i][0] = fq[i].pop_front();
        end else begin
          pipe[i][0] = $urandom();
        end
        if (fs || rs) begin
          fq[i].delete();
          exp_q[i].delete();
        end
        din[i]   = pipe[i][i];
        empty[i] = (fq[i].size() == 0);
      end
    end
  endtask

  task automatic mon_loop();
    bit          pstall [N];
    logic [31:0] pdata  [N];
    logic [31:0] e;
    bit          pfr;
    pfr = 1'b1;
    for (int i = 0; i < N; i++) pstall[i] = 1'b0;
    forever begin
      @(negedge clk);
      for (int i = 0; i < N; i++) begin
        chk(beat[i] == sx(m_beat[i]), "beat_cnt", i,
            beat[i], sx(m_beat[i]));
        chk(stall[i] == sx(m_stall[i]), "stall_cnt", i,
            stall[i], sx(m_stall[i]));
        if (rst || flush) begin
          chk(!pop[i], "pop_in_clear", i, 32'(pop[i]), 0);
        end else if (pop[i]) begin
          chk(fq[i].size() != 0, "pop_on_empty", i, 1, 0);
        end
        if (pfr) begin
          chk(!valid[i], "valid_after_clear", i,
              32'(valid[i]), 0);
        end
        if (pstall[i] && !pfr) begin
          chk(valid[i] && dout[i] == pdata[i], "hold", i,
              dout[i], pdata[i]);
        end
        if (!rst && valid[i] && ready[i]) begin
          chk(exp_q[i].size() != 0, "unexpected_beat", i,
              dout[i], 0);
          if (exp_q[i].size() != 0) begin
            e = exp_q[i].pop_front();
            chk(dout[i] == e, "data", i, dout[i], e);
          end
        end
        if (rst) begin
          m_beat[i]  = 0;
          m_stall[i] = 0;
        end else begin
          if (valid[i] && ready[i])  m_beat[i]++;
          if (valid[i] && !ready[i]) m_stall[i]++;
        end
        pstall[i] = !rst && valid[i] && !ready[i];
        pdata[i]  = dout[i];
      end
      pfr = rst || flush;
    end
  endtask

  task automatic wait_valid(input int i);
    int k;
    k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (!valid[i] && k < 60);
    chk(valid[i], "wait_valid", i, 32'(valid[i]), 1);
  endtask

  task automatic drain(input int bound);
    int k;
    bit busy;
    k = 0;
    busy = 1'b1;
    while (busy && k < bound) begin
      step();
      k++;
      busy = 1'b0;
      for (int i = 0; i < N; i++)
        if (exp_q[i].size() != 0) busy = 1'b1;
    end
    repeat (6) step();
    for (int i = 0; i < N; i++) begin
      chk(exp_q[i].size() == 0, "drain", i,
          32'(exp_q[i].size()), 0);
    end
  endtask

  initial begin
    int k;
    int sent;
    int nw;
    logic [31:0] w;
    total = 0;
    bad   = 0;
    rst   = 1'b1;
    flush = 1'b0;
    ready = '0;
    empty = '1;
    for (int i = 0; i < N; i++) begin
      din[i]     = '0;
      m_beat[i]  = 0;
      m_stall[i] = 0;
      for (int k2 = 0; k2 < 4; k2++) pipe[i][k2] = '0;
    end
    fork
      model_loop();
      mon_loop();
    join_none

    repeat (3) step();
    for (int i = 0; i < N; i++) begin
      chk(valid[i] == 1'b0, "rst_valid", i, 32'(valid[i]), 0);
      chk(dout[i] == '0, "rst_data", i, dout[i], 0);
      chk(pop[i] == 1'b0, "rst_pop", i, 32'(pop[i]), 0);
      chk(beat[i] == '0, "rst_beat", i, beat[i], 0);
      chk(stall[i] == '0, "rst_stall", i, stall[i], 0);
    end
    rst = 1'b0;
    repeat (5) step();

    // Streaming with ready held high.
    ready = '1;
    for (int v = 16; v < 32; v++) push_all(32'(v));
    k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (!pop[0] && k < 20);
    chk(pop[0], "first_pop", 0, 32'(pop[0]), 1);
    @(negedge clk);
    chk(!valid[0], "lat_early", 0, 32'(valid[0]), 0);
    @(negedge clk);
    chk(valid[0] && dout[0] == 32'h10, "lat_first", 0,
        dout[0], 32'h10);
    for (int v = 17; v < 32; v++) begin
      @(negedge clk);
      chk(valid[0] && dout[0] == 32'(v), "stream_gapless", 0,
          dout[0], 32'(v));
    end
    drain(200);
    for (int i = 0; i < N; i++) begin
      chk(beat[i] == sx(16), "stream_beats", i, beat[i], sx(16));
      chk(stall[i] == sx(0), "stream_stalls", i, stall[i], 0);
    end

    // Backpressure from the first valid.
    ready = '0;
    for (int v = 16; v < 32; v++) push_all(32'(v));
    wait_valid(1);
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      chk(!pop[1], "bp_no_pop", 1, 32'(pop[1]), 0);
      chk(dout[1] == 32'h10, "bp_hold", 1, dout[1], 32'h10);
    end
    chk(fq[1].size() == 13, "bp_buffered", 1,
        32'(16 - fq[1].size()), 3);
    step();
    ready = '1;
    for (int v = 16; v < 32; v++) begin
      @(negedge clk);
      chk(valid[1] && dout[1] == 32'(v), "bp_release", 1,
          dout[1], 32'(v));
    end
    drain(200);

    // Flush with words buffered and in flight.
    ready = '0;
    for (int v = 48; v < 56; v++) push_all(32'(v));
    wait_valid(2);
    step();
    flush = 1'b1;
    step();
    flush = 1'b0;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      for (int i = 0; i < N; i++)
        chk(!valid[i], "flush_drop", i, 32'(valid[i]), 0);
    end
    step();
    ready = '1;
    for (int v = 160; v < 168; v++) push_all(32'(v));
    wait_valid(2);
    chk(dout[2] == 32'hA0, "refill_first", 2, dout[2], 32'hA0);
    drain(200);

    // Random backpressure, 1000 words.
    sent = 0;
    while (sent < 1000) begin
      for (int i = 0; i < N; i++) ready[i] = $urandom_range(0, 1) == 1;
      nw = $urandom_range(0, 2);
      for (int j = 0; j < nw && sent < 1000; j++) begin
        w = $urandom();
        push_all(w);
        sent++;
      end
      step();
    end
    ready = '1;
    drain(4000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/evt_fifo_stream_adapter.md
# evt_fifo_stream_adapter

- Converts the pop/empty/data read side of the SRAM-backed event FIFO into a valid/ready stream for the next event-processing stage.
- Issues pops speculatively and tracks reads still in flight through the SRAM read latency.
- Holds returned words in a small skid buffer, so the stream sustains one event per cycle under continuous `ready_i`.
- Never loses or duplicates an event under backpressure.

## Interface
Parameters:
- `DATA_WIDTH`, 32, event word width; equals the upstream FIFO word width.
- `READ_LATENCY`, 1, cycles from a pop being issued to its word appearing on `fifo_data_i`; legal range 1..4.

Ports:
- `clk_i`  in  1  clock; single clock domain.
- `rst_i`  in  1  reset; synchronous, active-high.
- `flush_i`  in  1  discard buffered and in-flight words; asserted together with the upstream FIFO flush.
- `fifo_empty_i`  in  1  upstream FIFO empty flag.
- `fifo_pop_o`  out  1  pop strobe to the upstream FIFO.
- `fifo_data_i`  in  DATA_WIDTH  upstream read data.
- `valid_o`  out  1  stream valid.
- `ready_i`  in  1  stream ready.
- `data_o`  out  DATA_WIDTH  stream data.
- `beat_cnt_o`  out  32  accepted beats; statistics only.
- `stall_cnt_o`  out  32  cycles with `valid_o` & ~`ready_i`; statistics only.

## Operation
- Localparam `SKID_DEPTH = READ_LATENCY + 1`.
- `inflight_q` is a READ_LATENCY-deep shift register of tag bits.
  - A tag entering on pop marks that `fifo_data_i` is valid `READ_LATENCY` cycles later.
  - `inflight_cnt` is the popcount of `inflight_q`.
- The skid buffer is a circular FIFO of `SKID_DEPTH` words.
  - `occ_q` counts its entries, `0..SKID_DEPTH`.
  - Head and tail pointers wrap to 0 after `SKID_DEPTH-1`.
- `deq = valid_o & ready_i`.
- Pop rule: `fifo_pop_o = ~rst_i & ~flush_i & ~fifo_empty_i & (occ_q + inflight_cnt - deq < SKID_DEPTH)`.
  - The comparison is evaluated at width `$clog2(2*SKID_DEPTH)+1`; the subtraction never underflows.
- Capture: when the tag leaving `inflight_q` is 1, `fifo_data_i` is written at the tail in that same cycle.
  - By construction the buffer is never full at that point.
  - Overflow is a fatal assertion in simulation.
- Dequeue: `deq` advances the head.
- Simultaneous capture and dequeue leaves `occ_q` unchanged and is legal at every occupancy, including `SKID_DEPTH`.
- `valid_o = (occ_q != 0)`.
- `data_o` = buffer head, registered storage, no combinational path from `fifo_data_i`.
- While `valid_o & ~ready_i`, `valid_o` and `data_o` stay stable (AXI-style rule).
- `flush_i`, effective at the next edge:
  - `occ_q`, pointers and all `inflight_q` tags clear; words returning later are dropped.
  - `fifo_pop_o` is 0 in the flush cycle.
  - `valid_o` is 0 from the next cycle.
  - Statistics counters are not cleared.
- `rst_i` behaves like flush and additionally clears the counters.
  - Reset values: `valid_o` 0, `data_o` 0, `fifo_pop_o` 0, `beat_cnt_o` 0, `stall_cnt_o` 0.
  - Reset mid-stream drops all pending words.
- Counters saturate at `32'hFFFF_FFFF`.

## Timing
- First-word latency: pop at cycle N → word captured at end of cycle N+READ_LATENCY → `valid_o` high in cycle N+READ_LATENCY+1.
- Sustained throughput: 1 beat/cycle with `ready_i` held 1 and FIFO non-empty.
- Combinational path `ready_i` → `fifo_pop_o` is intended.
- No path from `fifo_data_i` to any output.
- After `ready_i` falls, at most `READ_LATENCY` further words arrive.
  - The buffer absorbs them and pops stop until space returns.

## Configuration
- `EVT_FIFO_ADAPTER_STATS_EN` defined: `beat_cnt_o`/`stall_cnt_o` registers are implemented as above.
- Not defined: counters are not instantiated and both outputs are tied to 0.
- Data-path behaviour is identical either way.

## Structure
- Shared package `evt_stream_pkg`:
  - `evt_stream_stats_t` (two 32-bit counters).
  - Localparam `EVT_MAX_READ_LATENCY = 4`.
- Sub-module `evt_skid_buffer` (params `DATA_WIDTH`, `DEPTH`):
  - Holds the circular storage, `occ_q` and head/tail pointers.
  - Exposes write, read, `occupancy`, `head_data`.
- The top keeps the inflight shift register, the pop rule, flush handling and the statistics.

## Test plan
- Reset then idle:
  - `rst_i` high 3 cycles, FIFO empty → all outputs 0.
  - `fifo_pop_o` never asserts.
- Streaming, `READ_LATENCY=1`:
  - FIFO preloaded with 0x10..0x1F, `ready_i`=1 → pops in cycles 0..15.
  - `data_o` 0x10..0x1F on consecutive cycles starting cycle 2.
  - `beat_cnt_o`=16, `stall_cnt_o`=0.
- Backpressure, `READ_LATENCY=2`:
  - `ready_i`=0 from the first `valid_o` → exactly 3 words buffered, `fifo_pop_o` 0 afterwards.
  - `data_o` holds 0x10.
  - Release `ready_i` → in-order 0x10,0x11,0x12,… with no gap.
- Random `ready_i` at 50%, 1000 words, `READ_LATENCY` 1..4:
  - Output sequence equals input sequence.
  - No overflow assertion.
  - `stall_cnt_o` equals the count of `valid_o`&~`ready_i` cycles.
- Flush with 2 in-flight and 2 buffered words:
  - `valid_o`=0 next cycle.
  - Late-returning words dropped.
  - First word after refill is the new 0xA0.
- Macro undefined:
  - Same streaming test passes.
  - `beat_cnt_o`=`stall_cnt_o`=0 throughout.
